match_judge: RTL and testbench
==============================

MATCH_JUDGE -- requirements
Module: match_judge

Interface
REQ-001 SHALL have parameter WIN_TARGET, default 3: wins or losses that end a game.
REQ-002 SHALL have parameter MAX_ROUNDS, default 9: rounds that end a game.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port resetn  in  1  synchronous, active-low reset.
REQ-005 SHALL have port start  in  1  begin a new game (sampled in IDLE and DONE only).
REQ-006 SHALL have port player_valid  in  1  player move offered.
REQ-007 SHALL have port player_move  in  2  00 rock, 01 paper, 10 scissors, 11 illegal.
REQ-008 SHALL have port cpu_force_en  in  1  debug: use cpu_force_move instead of internal generator.
REQ-009 SHALL have port cpu_force_move  in  2  debug CPU move (00/01/10).
REQ-010 SHALL have port player_ready  out  1  high only in WAIT_MOVE.
REQ-011 SHALL have port matchresult  out  2  00 none, 01 draw, 10 win, 11 lose (scoreupdate encoding).
REQ-012 SHALL have port result_valid  out  1  one-cycle pulse with matchresult.
REQ-013 SHALL have port cpu_move  out  2  CPU move of the last judged round.
REQ-014 SHALL have ports wins, losses, draws, rounds  out  4 each  running totals.
REQ-015 SHALL have port game_over  out  1  high in DONE.
REQ-016 SHALL have port final_result  out  2  10 player won, 11 CPU won, 01 tie; valid when game_over.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT_MOVE, JUDGE, REPORT, DONE.
REQ-018 IDLE: start=1 -> WAIT_MOVE, counters cleared; else stay.
REQ-019 WAIT_MOVE: accept when player_valid & player_ready & player_move!=11 -> JUDGE; latch player move and CPU move on that edge.
REQ-020 Illegal move (11) SHALL be ignored: no state change, no counter change, player_ready stays high.
REQ-021 CPU generator: mod-3 counter cpu_seed, reset 0, increments 0->1->2->0 every clock in every state; latched CPU move = cpu_force_en ? cpu_force_move : cpu_seed.
REQ-022 cpu_force_move=11 with cpu_force_en=1 SHALL latch 00 (rock).
REQ-023 JUDGE (one cycle): d = (player - cpu) mod 3; d=0 draw, d=1 win, d=2 lose; update exactly one of wins/losses/draws and rounds by +1 on exit edge.
REQ-024 REPORT (one cycle): matchresult = judged code, result_valid=1, cpu_move updated; matchresult=00 and result_valid=0 in every other state.
REQ-025 Latency: result_valid SHALL assert in the 2nd cycle after the accepting edge; next player_ready 3 cycles after accept.
REQ-026 REPORT exit: wins==WIN_TARGET or losses==WIN_TARGET or rounds==MAX_ROUNDS -> DONE; else WAIT_MOVE.
REQ-027 DONE: final_result = 10 if wins>losses, 11 if losses>wins, 01 if equal; counters hold; start -> clear counters, final_result=00, WAIT_MOVE.
REQ-028 Counters are 4-bit, never exceed terminating values, SHALL not wrap.
REQ-029 start outside IDLE/DONE SHALL be ignored.
REQ-030 player_valid outside WAIT_MOVE SHALL be ignored; no input buffering.

Reset
REQ-031 resetn=0 at rising edge SHALL force IDLE, cpu_seed=0, cpu_move=00, all counters 0, matchresult=00, result_valid=0, player_ready=0, game_over=0, final_result=00.
REQ-032 Reset SHALL take priority over all other inputs in any state, including mid-REPORT (pulse truncated, no counter update).

Verification
REQ-033 Reset then start, cpu_force_en=1 move 00, player 01 -> result_valid 2 cycles after accept, matchresult=10, wins=1, rounds=1.
REQ-034 Force CPU 10, player 01 -> matchresult=11, losses=1; force 01, player 01 -> matchresult=01, draws=1, counters else unchanged.
REQ-035 Player 11 held 5 cycles in WAIT_MOVE -> no result_valid, player_ready stays 1, counters unchanged.
REQ-036 Three player wins with defaults -> game_over=1, final_result=10, rounds=3; further player_valid ignored; start -> counters 0, WAIT_MOVE.
REQ-037 Nine alternating draws -> DONE after round 9, final_result=01, draws=9.
REQ-038 resetn=0 during REPORT -> next cycle IDLE, result_valid=0, all counters 0; cpu_force_en=0 accept 4 edges after reset release -> cpu_move=01.

Source files
------------

// File: rtl/match_judge.sv
// match_judge: rock/paper/scissors game controller. It accepts player moves,
// judges them against an internal or forced CPU move, keeps running totals and
// ends the game on a win/loss target or a round limit.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | after reset, waiting for start
// WAIT_MOVE | player_ready high, waiting for a legal player move
// JUDGE     | one cycle: compare moves, bump totals on exit edge
// REPORT    | one cycle: result_valid pulse with matchresult and cpu_move
// DONE      | game over, final_result valid, totals held until start
module match_judge #(
    parameter int WIN_TARGET = 3,
    parameter int MAX_ROUNDS = 9
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       player_valid,
    input  logic [1:0] player_move,
    input  logic       cpu_force_en,
    input  logic [1:0] cpu_force_move,
    output logic       player_ready,
    output logic [1:0] matchresult,
    output logic       result_valid,
    output logic [1:0] cpu_move,
    output logic [3:0] wins,
    output logic [3:0] losses,
    output logic [3:0] draws,
    output logic [3:0] rounds,
    output logic       game_over,
    output logic [1:0] final_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_MOVE,
        S_JUDGE,
        S_REPORT,
        S_DONE
    } state_t;

    localparam logic [3:0] WIN_T = 4'(WIN_TARGET);
    localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);

    localparam logic [1:0] RES_DRAW = 2'b01;
    localparam logic [1:0] RES_WIN  = 2'b10;
    localparam logic [1:0] RES_LOSE = 2'b11;

    state_t     state, state_nxt;
    logic [1:0] cpu_seed;
    logic [1:0] player_q;
    logic [1:0] cpu_q;
    logic [1:0] result_q;
    logic [1:0] judge_code;
    logic       accept;
    logic       game_end;
    logic       clear_game;

    assign accept     = (state == S_WAIT_MOVE) && player_valid && (player_move != 2'b11);
    assign game_end   = (wins == WIN_T) || (losses == WIN_T) || (rounds == MAX_R);
    assign clear_game = ((state == S_IDLE) || (state == S_DONE)) && start;

    // Judge the latched moves: equal is a draw, player one step ahead (mod 3) wins.
    always_comb begin
        judge_code = RES_LOSE;
        if (player_q == cpu_q) begin
            judge_code = RES_DRAW;
        end else if ((player_q == 2'd1 && cpu_q == 2'd0) ||
                     (player_q == 2'd2 && cpu_q == 2'd1) ||
                     (player_q == 2'd0 && cpu_q == 2'd2)) begin
            judge_code = RES_WIN;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start)  state_nxt = S_WAIT_MOVE;
            S_WAIT_MOVE: if (accept) state_nxt = S_JUDGE;
            S_JUDGE:     state_nxt = S_REPORT;
            S_REPORT:    state_nxt = game_end ? S_DONE : S_WAIT_MOVE;
            S_DONE:      if (start)  state_nxt = S_WAIT_MOVE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // CPU move generator, move latches, totals and last judged CPU move.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cpu_seed <= 2'd0;
            player_q <= 2'd0;
            cpu_q    <= 2'd0;
            result_q <= 2'b00;
            cpu_move <= 2'b00;
            wins     <= 4'd0;
            losses   <= 4'd0;
            draws    <= 4'd0;
            rounds   <= 4'd0;
        end else begin
            cpu_seed <= (cpu_seed == 2'd2) ? 2'd0 : cpu_seed + 2'd1;
            if (clear_game) begin
                wins   <= 4'd0;
                losses <= 4'd0;
                draws  <= 4'd0;
                rounds <= 4'd0;
            end
            if (accept) begin
                player_q <= player_move;
                if (cpu_force_en) begin
                    // An illegal forced move falls back to rock.
                    cpu_q <= (cpu_force_move == 2'b11) ? 2'd0 : cpu_force_move;
                end else begin
                    cpu_q <= cpu_seed;
                end
            end
            if (state == S_JUDGE) begin
                result_q <= judge_code;
                cpu_move <= cpu_q;
                if (rounds != 4'hF) rounds <= rounds + 4'd1;
                case (judge_code)
                    RES_WIN:  if (wins   != 4'hF) wins   <= wins   + 4'd1;
                    RES_LOSE: if (losses != 4'hF) losses <= losses + 4'd1;
                    default:  if (draws  != 4'hF) draws  <= draws  + 4'd1;
                endcase
            end
        end
    end

    // State-decoded outputs.
    always_comb begin
        player_ready = (state == S_WAIT_MOVE);
        result_valid = (state == S_REPORT);
        matchresult  = (state == S_REPORT) ? result_q : 2'b00;
        game_over    = (state == S_DONE);
        final_result = 2'b00;
        if (state == S_DONE) begin
            if (wins > losses)      final_result = RES_WIN;
            else if (losses > wins) final_result = RES_LOSE;
            else                    final_result = RES_DRAW;
        end
    end

endmodule

// File: tb/tb_match_judge.sv
// Directed bench for match_judge: each task drives one scenario and checks
// hand-computed expectations inline.
module tb_match_judge;

    logic       clk;
    logic       resetn;
    logic       start;
    logic       player_valid;
    logic [1:0] player_move;
    logic       cpu_force_en;
    logic [1:0] cpu_force_move;
    logic       player_ready;
    logic [1:0] matchresult;
    logic       result_valid;
    logic [1:0] cpu_move;
    logic [3:0] wins;
    logic [3:0] losses;
    logic [3:0] draws;
    logic [3:0] rounds;
    logic       game_over;
    logic [1:0] final_result;

    int n_cmp  = 0;
    int n_fail = 0;

    match_judge dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .player_valid  (player_valid),
        .player_move   (player_move),
        .cpu_force_en  (cpu_force_en),
        .cpu_force_move(cpu_force_move),
        .player_ready  (player_ready),
        .matchresult   (matchresult),
        .result_valid  (result_valid),
        .cpu_move      (cpu_move),
        .wins          (wins),
        .losses        (losses),
        .draws         (draws),
        .rounds        (rounds),
        .game_over     (game_over),
        .final_result  (final_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn         = 1'b0;
        start          = 1'b0;
        player_valid   = 1'b0;
        player_move    = 2'b00;
        cpu_force_en   = 1'b0;
        cpu_force_move = 2'b00;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Play one round from WAIT_MOVE with a forced CPU move. Returns what was
    // seen in the REPORT cycle and whether the pulse timing was right.
    task automatic play_round(input logic [1:0] pm, input logic [1:0] cm,
                              output logic [1:0] res, output logic [1:0] cpu_seen,
                              output bit timing_ok);
        bit v_judge;
        bit v_report;
        player_valid   = 1'b1;
        player_move    = pm;
        cpu_force_en   = 1'b1;
        cpu_force_move = cm;
        step();
        player_valid = 1'b0;
        v_judge      = result_valid;
        step();
        v_report  = result_valid;
        res       = matchresult;
        cpu_seen  = cpu_move;
        timing_ok = !v_judge && v_report;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({player_ready, result_valid, game_over, matchresult, final_result, cpu_move} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 000000000",
                     {player_ready, result_valid, game_over, matchresult, final_result, cpu_move});
        end
        n_cmp++;
        if ({wins, losses, draws, rounds} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %h required 0000", {wins, losses, draws, rounds});
        end
        do_start();
        n_cmp++;
        if (player_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_ready: got %b required 1", player_ready);
        end
    endtask

    task automatic test_outcomes();
        logic [1:0] res;
        logic [1:0] cs;
        bit         ok;
        play_round(2'b01, 2'b00, res, cs, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL win_latency: result_valid not seen exactly 2 cycles after accept");
        end
        n_cmp++;
        if (res !== 2'b10 || wins !== 4'd1 || rounds !== 4'd1) begin
            n_fail++;
            $display("FAIL win_round: got res=%b wins=%0d rounds=%0d required res=10 wins=1 rounds=1",
                     res, wins, rounds);
        end
        n_cmp++;
        if (player_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_round: got %b required 1", player_ready);
        end
        play_round(2'b01, 2'b10, res, cs, ok);
        n_cmp++;
        if (!ok || res !== 2'b11 || losses !== 4'd1 || cs !== 2'b10) begin
            n_fail++;
            $display("FAIL lose_round: got ok=%0d res=%b losses=%0d cpu=%b required ok=1 res=11 losses=1 cpu=10",
                     ok, res, losses, cs);
        end
        play_round(2'b01, 2'b01, res, cs, ok);
        n_cmp++;
        if (!ok || res !== 2'b01 || {wins, losses, draws, rounds} !== 16'h1113) begin
            n_fail++;
            $display("FAIL draw_round: got ok=%0d res=%b w/l/d/r=%h required ok=1 res=01 w/l/d/r=1113",
                     ok, res, {wins, losses, draws, rounds});
        end
        n_cmp++;
        if (matchresult !== 2'b00 || result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_result: got mr=%b rv=%b required 00 0", matchresult, result_valid);
        end
    endtask

    task automatic test_illegal();
        logic [1:0] res;
        logic [1:0] cs;
        bit         ok;
        int         bad;
        bad          = 0;
        player_valid = 1'b1;
        player_move  = 2'b11;
        start        = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (result_valid !== 1'b0 || player_ready !== 1'b1) bad++;
        end
        player_valid = 1'b0;
        start        = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL illegal_move_hold: %0d cycles with pulse or ready low, required 0", bad);
        end
        n_cmp++;
        if ({wins, losses, draws, rounds} !== 16'h1113) begin
            n_fail++;
            $display("FAIL illegal_counters: got %h required 1113", {wins, losses, draws, rounds});
        end
        cpu_move_check: begin
            play_round(2'b00, 2'b11, res, cs, ok);
            n_cmp++;
            if (res !== 2'b01 || cs !== 2'b00 || draws !== 4'd2) begin
                n_fail++;
                $display("FAIL forced_illegal_cpu: got res=%b cpu=%b draws=%0d required 01 00 2",
                         res, cs, draws);
            end
        end
    endtask

    task automatic test_win_game();
        logic [1:0] res;
        logic [1:0] cs;
        bit         ok;
        int         bad;
        do_reset();
        do_start();
        play_round(2'b00, 2'b10, res, cs, ok);
        play_round(2'b10, 2'b01, res, cs, ok);
        n_cmp++;
        if (game_over !== 1'b0 || wins !== 4'd2) begin
            n_fail++;
            $display("FAIL win_game_mid: got go=%b wins=%0d required 0 2", game_over, wins);
        end
        play_round(2'b01, 2'b00, res, cs, ok);
        n_cmp++;
        if (game_over !== 1'b1 || final_result !== 2'b10 || rounds !== 4'd3 || wins !== 4'd3) begin
            n_fail++;
            $display("FAIL win_game_done: got go=%b fr=%b rounds=%0d wins=%0d required 1 10 3 3",
                     game_over, final_result, rounds, wins);
        end
        bad          = 0;
        player_valid = 1'b1;
        player_move  = 2'b00;
        for (int i = 0; i < 4; i++) begin
            step();
            if (result_valid !== 1'b0 || player_ready !== 1'b0 || rounds !== 4'd3) bad++;
        end
        player_valid = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL done_ignores_move: %0d bad cycles, required 0", bad);
        end
        do_start();
        n_cmp++;
        if ({wins, losses, draws, rounds} !== 16'd0 || player_ready !== 1'b1 ||
            game_over !== 1'b0 || final_result !== 2'b00) begin
            n_fail++;
            $display("FAIL restart: got cnt=%h ready=%b go=%b fr=%b required 0000 1 0 00",
                     {wins, losses, draws, rounds}, player_ready, game_over, final_result);
        end
    endtask

    task automatic test_lose_game();
        logic [1:0] res;
        logic [1:0] cs;
        bit         ok;
        for (int i = 0; i < 3; i++) play_round(2'b10, 2'b00, res, cs, ok);
        n_cmp++;
        if (game_over !== 1'b1 || final_result !== 2'b11 || losses !== 4'd3) begin
            n_fail++;
            $display("FAIL lose_game: got go=%b fr=%b losses=%0d required 1 11 3",
                     game_over, final_result, losses);
        end
        do_start();
    endtask

    task automatic test_draw_game();
        logic [1:0] res;
        logic [1:0] cs;
        logic [1:0] mv;
        bit         ok;
        bit         early;
        early = 0;
        for (int i = 0; i < 9; i++) begin
            mv = 2'(i % 3);
            play_round(mv, mv, res, cs, ok);
            if (i < 8 && game_over !== 1'b0) early = 1;
        end
        n_cmp++;
        if (early) begin
            n_fail++;
            $display("FAIL draw_game_early: game_over seen before round 9, required none");
        end
        n_cmp++;
        if (game_over !== 1'b1 || final_result !== 2'b01 || draws !== 4'd9 || rounds !== 4'd9) begin
            n_fail++;
            $display("FAIL draw_game_done: got go=%b fr=%b draws=%0d rounds=%0d required 1 01 9 9",
                     game_over, final_result, draws, rounds);
        end
    endtask

    task automatic test_reset_in_report();
        int exp_seed;
        do_start();
        player_valid   = 1'b1;
        player_move    = 2'b01;
        cpu_force_en   = 1'b1;
        cpu_force_move = 2'b00;
        step();
        player_valid = 1'b0;
        step();
        n_cmp++;
        if (result_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_report: got rv=%b required 1", result_valid);
        end
        resetn = 1'b0;
        step();
        n_cmp++;
        if (result_valid !== 1'b0 || player_ready !== 1'b0 ||
            {wins, losses, draws, rounds} !== 16'd0 || cpu_move !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_in_report: got rv=%b ready=%b cnt=%h cpu=%b required 0 0 0000 00",
                     result_valid, player_ready, {wins, losses, draws, rounds}, cpu_move);
        end
        // Seed is 0 entering edge 1 after release; edges 1-4 advance it, edge 5 accepts.
        resetn       = 1'b1;
        cpu_force_en = 1'b0;
        exp_seed     = 4 % 3;
        do_start();
        step();
        step();
        step();
        player_valid = 1'b1;
        player_move  = 2'b01;
        step();
        player_valid = 1'b0;
        step();
        n_cmp++;
        if (cpu_move !== 2'(exp_seed) || matchresult !== 2'b01) begin
            n_fail++;
            $display("FAIL internal_cpu: got cpu=%b mr=%b required %b 01",
                     cpu_move, matchresult, 2'(exp_seed));
        end
    endtask

    initial begin
        test_reset();
        test_outcomes();
        test_illegal();
        test_win_game();
        test_lose_game();
        test_draw_game();
        test_reset_in_report();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
